// File: rtl/hm_trn_pkg.sv
// hm_trn_pkg: shared constants, FSM states and index helper for the TRN arbiter.
package hm_trn_pkg;
  localparam int HM_NMASTER = 5;
  localparam int HM_GNT_W = 3;
  typedef enum logic {ST_IDLE, ST_LOCK} hm_state_e;
  function automatic logic [HM_GNT_W-1:0] hm_inc_mod(input logic [HM_GNT_W-1:0] i);
    return (i == HM_GNT_W'(HM_NMASTER - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/hm_trn_arb5_rr_pick.sv
// hm_rr_pick: first requester in round-robin order starting at ptr.
module hm_rr_pick
  import hm_trn_pkg::*;
(
  input  logic [HM_NMASTER-1:0] req,
  input  logic [HM_GNT_W-1:0]   ptr,
  output logic [HM_GNT_W-1:0]   pick,
  output logic                  any
);
  logic [7:0]          w_req_x;
  logic [HM_GNT_W:0]   w_sum;
  logic [HM_GNT_W-1:0] w_idx;
  assign w_req_x = 8'(req);
  assign any = |req;
  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    pick = ptr;
    w_sum = '0;
    w_idx = '0;
    for (int k = HM_NMASTER - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (HM_GNT_W + 1)'(k);
      w_idx = HM_GNT_W'((w_sum >= (HM_GNT_W + 1)'(HM_NMASTER)) ? w_sum - (HM_GNT_W + 1)'(HM_NMASTER) : w_sum);
      if (w_req_x[w_idx]) pick = w_idx;
    end
  end
endmodule

// File: rtl/hm_trn_arb5.sv
// hm_trn_arb5: packet-aware round-robin arbiter for the 5-master TRN transmit bus.
// Grant locks from SOF accept to EOF accept; a watchdog aborts stalled packets.
module hm_trn_arb5
  import hm_trn_pkg::*;
#(
  parameter int NMASTER = HM_NMASTER,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                       trn_clk,
  input  logic                       trn_rst,
  input  logic [NMASTER-1:0]         req,
  input  logic                       s_trn_tsof_n,
  input  logic                       s_trn_teof_n,
  input  logic                       s_trn_tsrc_rdy_n,
  input  logic                       s_trn_tdst_rdy_n,
  output logic [$clog2(NMASTER)-1:0] gnt,
  output logic                       gnt_valid,
  output logic                       busy,
  output logic                       timeout
);
  hm_state_e           r_state, w_state_nxt;
  logic [HM_GNT_W-1:0] r_gnt, w_gnt_nxt, r_ptr, w_ptr_nxt, w_pick;
  logic [TW-1:0]       r_cnt, w_cnt_nxt;
  logic [7:0]          w_req_x;
  logic                w_acc, w_sof, w_eof, w_any, w_abort;
  logic                r_rearb, w_rearb_nxt, r_gnt_valid, r_busy, r_timeout;
  assign w_acc = ~s_trn_tsrc_rdy_n & ~s_trn_tdst_rdy_n;
  assign w_sof = ~s_trn_tsof_n;
  assign w_eof = ~s_trn_teof_n;
  assign w_req_x = 8'(req);
  hm_rr_pick u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );
  // After a packet ends the old owner must not re-park, so the first IDLE cycle forces a fresh pick.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    w_rearb_nxt = 1'b0;
    w_cnt_nxt = '0;
    w_abort = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_acc && w_sof && !w_eof) w_state_nxt = ST_LOCK;
      else if (w_acc && w_sof) begin
        w_ptr_nxt = hm_inc_mod(r_gnt);
        w_rearb_nxt = 1'b1;
      end else if ((r_rearb || !w_req_x[r_gnt]) && w_any) w_gnt_nxt = w_pick;
    end else begin
      w_abort = !w_acc && (TIMEOUT != 0) && (r_cnt == TW'(TIMEOUT - 1));
      w_cnt_nxt = w_acc ? '0 : r_cnt + 1'b1;
      if ((w_acc && w_eof) || w_abort) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt = hm_inc_mod(r_gnt);
        w_rearb_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
    end
  end
  always_ff @(posedge trn_clk) begin
    if (trn_rst) begin
      r_state <= ST_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_rearb <= 1'b0;
      r_gnt_valid <= 1'b0;
      r_busy <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      r_rearb <= w_rearb_nxt;
      r_gnt_valid <= w_req_x[w_gnt_nxt];
      r_busy <= (w_state_nxt == ST_LOCK);
      r_timeout <= w_abort;
    end
  end
  assign gnt = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign busy = r_busy;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_hm_trn_arb5.sv
// tb_hm_trn_arb5: directed scenarios checked against a per-cycle arbitration model.
module tb_hm_trn_arb5;
  localparam int TMO = 8;
  logic       trn_clk, trn_rst;
  logic [4:0] req;
  logic       s_trn_tsof_n, s_trn_teof_n, s_trn_tsrc_rdy_n, s_trn_tdst_rdy_n;
  logic [2:0] gnt;
  logic       gnt_valid, busy, timeout;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  hm_trn_arb5 #(.NMASTER(5), .TIMEOUT(TMO), .TW(11)) dut (
    .trn_clk          (trn_clk),
    .trn_rst          (trn_rst),
    .req              (req),
    .s_trn_tsof_n     (s_trn_tsof_n),
    .s_trn_teof_n     (s_trn_teof_n),
    .s_trn_tsrc_rdy_n (s_trn_tsrc_rdy_n),
    .s_trn_tdst_rdy_n (s_trn_tdst_rdy_n),
    .gnt              (gnt),
    .gnt_valid        (gnt_valid),
    .busy             (busy),
    .timeout          (timeout)
  );

  initial trn_clk = 0;
  always #5 trn_clk = ~trn_clk;

  typedef struct packed {
    bit lock;
    int gnt;
    int ptr;
    bit valid;
    bit tmo;
    int stall;
    bit fresh;
  } mdl_t;
  mdl_t m;

  // One clock of the arbitration rules: in a packet, count stalled cycles; out of one,
  // keep the current owner if it still asks, unless a packet just finished.
  function automatic mdl_t step(mdl_t c, logic [4:0] r, bit sof, bit eof, bit acc);
    mdl_t n = c;
    bit found = 0;
    n.tmo = 0;
    n.fresh = 0;
    if (!c.lock) begin
      if (acc && sof && !eof) begin
        n.lock = 1;
        n.stall = 0;
      end else if (acc && sof) begin
        n.ptr = (c.gnt + 1) % 5;
        n.fresh = 1;
      end else if (c.fresh || !r[c.gnt]) begin
        for (int k = 0; k < 5; k++)
          if (!found && r[(c.ptr + k) % 5]) begin
            n.gnt = (c.ptr + k) % 5;
            found = 1;
          end
      end
    end else begin
      n.stall = acc ? 0 : c.stall + 1;
      if ((acc && eof) || (!acc && TMO > 0 && n.stall >= TMO)) begin
        n.tmo = !(acc && eof);
        n.lock = 0;
        n.ptr = (c.gnt + 1) % 5;
        n.fresh = 1;
        n.stall = 0;
      end
    end
    n.valid = r[n.gnt];
    return n;
  endfunction

  always @(posedge trn_clk) begin
    if (trn_rst) begin
      m <= '0;
      chk_en <= 1;
    end else
      m <= step(m, req, !s_trn_tsof_n, !s_trn_teof_n, !s_trn_tsrc_rdy_n && !s_trn_tdst_rdy_n);
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge trn_clk) begin
    if (chk_en) begin
      cmp("model gnt", int'(gnt), m.gnt);
      cmp("model gnt_valid", int'(gnt_valid), int'(m.valid));
      cmp("model busy", int'(busy), int'(m.lock));
      cmp("model timeout", int'(timeout), int'(m.tmo));
    end
  end

  task automatic cyc(input logic [4:0] r, input bit sof, input bit eof, input bit src, input bit dst);
    req = r;
    s_trn_tsof_n = !sof;
    s_trn_teof_n = !eof;
    s_trn_tsrc_rdy_n = !src;
    s_trn_tdst_rdy_n = !dst;
    @(posedge trn_clk);
    #1;
  endtask

  task automatic do_reset();
    trn_rst = 1;
    cyc(5'b0, 0, 0, 0, 0);
    cyc(5'b0, 0, 0, 0, 0);
    trn_rst = 0;
  endtask

  initial begin
    trn_rst = 1;
    req = 0;
    s_trn_tsof_n = 1;
    s_trn_teof_n = 1;
    s_trn_tsrc_rdy_n = 1;
    s_trn_tdst_rdy_n = 1;
    do_reset();
    cmp("rst gnt", gnt, 0);
    cmp("rst gnt_valid", gnt_valid, 0);
    cmp("rst busy", busy, 0);
    cmp("rst timeout", timeout, 0);
    cyc(5'b00100, 0, 0, 0, 0);
    cmp("req2 gnt", gnt, 2);
    cmp("req2 gnt_valid", gnt_valid, 1);
    cmp("req2 busy", busy, 0);
    // master 1, four beats with destination backpressure
    cyc(5'b00010, 0, 0, 0, 0);
    cmp("pre m1 gnt", gnt, 1);
    cyc(5'b11111, 1, 0, 1, 1);
    cmp("m1 sof busy", busy, 1);
    cyc(5'b11111, 0, 0, 1, 0);
    cyc(5'b11111, 0, 0, 1, 1);
    cyc(5'b11111, 0, 0, 1, 0);
    cmp("m1 mid gnt", gnt, 1);
    cmp("m1 mid busy", busy, 1);
    cyc(5'b11111, 0, 0, 1, 1);
    cyc(5'b11111, 0, 1, 1, 1);
    cmp("m1 eof busy", busy, 0);
    cmp("m1 eof gnt", gnt, 1);
    cyc(5'b11111, 0, 0, 0, 0);
    cmp("m1 next gnt", gnt, 2);
    // single-beat packets rotate through all masters
    do_reset();
    cyc(5'b11111, 0, 0, 0, 0);
    cmp("rr start gnt", gnt, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(5'b11111, 1, 1, 1, 1);
      cmp("rr beat busy", busy, 0);
      cyc(5'b11111, 0, 0, 0, 0);
      cmp("rr gnt", gnt, (i + 1) % 5);
    end
    // watchdog on master 3
    cyc(5'b01000, 0, 0, 0, 0);
    cmp("wd pre gnt", gnt, 3);
    cyc(5'b01000, 1, 0, 1, 1);
    cmp("wd sof busy", busy, 1);
    for (int i = 1; i <= TMO; i++) begin
      cyc(5'b01000, 0, 0, 0, 0);
      cmp("wd timeout", timeout, (i == TMO) ? 1 : 0);
      cmp("wd busy", busy, (i == TMO) ? 0 : 1);
    end
    cyc(5'b11111, 0, 0, 0, 0);
    cmp("wd pulse end", timeout, 0);
    cmp("wd next gnt", gnt, 4);
    // reset in the middle of a master-2 packet
    cyc(5'b00100, 0, 0, 0, 0);
    cmp("mid pre gnt", gnt, 2);
    cyc(5'b00100, 1, 0, 1, 1);
    cyc(5'b00100, 0, 0, 1, 1);
    cmp("mid busy", busy, 1);
    trn_rst = 1;
    cyc(5'b00100, 0, 0, 1, 1);
    cmp("mid rst gnt", gnt, 0);
    cmp("mid rst busy", busy, 0);
    cmp("mid rst timeout", timeout, 0);
    trn_rst = 0;
    cyc(5'b11110, 0, 0, 0, 0);
    cmp("ptr after rst gnt", gnt, 1);
    // master 0 SOF held off by the endpoint
    cyc(5'b00001, 0, 0, 0, 0);
    cmp("bp pre gnt", gnt, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(5'b11111, 1, 0, 1, 0);
      cmp("bp gnt", gnt, 0);
      cmp("bp busy", busy, 0);
    end
    cyc(5'b11111, 1, 0, 1, 1);
    cmp("bp lock busy", busy, 1);
    cmp("bp lock gnt", gnt, 0);
    cyc(5'b11111, 0, 1, 1, 1);
    cmp("bp eof busy", busy, 0);
    cyc(5'b11111, 0, 0, 0, 0);
    cmp("bp next gnt", gnt, 1);
    cyc(5'b00000, 0, 0, 0, 0);
    cmp("idle gnt_valid", gnt_valid, 0);
    cmp("idle gnt", gnt, 1);
    cyc(5'b00000, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hm_trn_arb5.md
# hm_trn_arb5

Packet-aware round-robin arbiter for the 5-master TRN transmit interconnect (`hm_conbus5`). It watches the shared slave-side TRN transmit handshake and drives the `gnt` select. Once a master's start-of-frame beat is accepted, the grant is locked until that master's end-of-frame beat is accepted, so TLPs from different masters never interleave. A watchdog releases a grant stuck mid-packet.

## Interface
- `NMASTER`, 5: number of masters; `gnt` is `$clog2(NMASTER)` = 3 bits wide.
- `TIMEOUT`, 1024: cycles in LOCK with no accepted beat before abort; 0 disables the watchdog.
- `TW`, 11: width of the watchdog counter; must hold `TIMEOUT`.

Ports:
- `trn_clk`  in  1  the single clock; everything is sampled on the rising edge.
- `trn_rst`  in  1  synchronous, active-high reset.
- `req`  in  5  `req[i]` = ~`mi_trn_tsrc_rdy_n`; bit i is master i.
- `s_trn_tsof_n`  in  1  muxed slave SOF (active low).
- `s_trn_teof_n`  in  1  muxed slave EOF (active low).
- `s_trn_tsrc_rdy_n`  in  1  muxed slave source ready.
- `s_trn_tdst_rdy_n`  in  1  endpoint destination ready.
- `gnt`  out  3  registered index of the granted master; drives the `hm_conbus5` mux.
- `gnt_valid`  out  1  high when `req[gnt]` was asserted at the last grant decision.
- `busy`  out  1  high in LOCK.
- `timeout`  out  1  one-cycle pulse when the watchdog aborts a packet.

## Operation
- Beat accept: `acc` = ~`s_trn_tsrc_rdy_n` & ~`s_trn_tdst_rdy_n`.
- The round-robin pointer `ptr` (0..4) names the highest-priority master. Candidate order is ptr, ptr+1, … mod 5.
- **IDLE state**
  - If `acc` & ~`s_trn_tsof_n` & `s_trn_teof_n`: go to LOCK and hold `gnt`.
  - If `acc` & ~`s_trn_tsof_n` & ~`s_trn_teof_n` (single-beat TLP): stay in IDLE, set `ptr` = `gnt`+1 mod 5, then re-arbitrate.
  - Else if `req[gnt]` is high: hold `gnt` (park). A backpressured master never loses its grant before SOF is accepted.
  - Else if any `req` bit is high: `gnt` = first requester in candidate order.
  - Else: hold `gnt` and clear `gnt_valid`.
- **LOCK state**
  - `gnt` is frozen. `req` is ignored except `req[gnt]`, which feeds `gnt_valid`.
  - If `acc` & ~`s_trn_teof_n`: go to IDLE, set `ptr` = `gnt`+1 mod 5.
  - Watchdog counter resets to 0 on every `acc` and increments otherwise.
  - When the counter reaches `TIMEOUT`-1 with no `acc`: go to IDLE, set `ptr` = `gnt`+1, pulse `timeout` for one cycle.
- Re-arbitration after EOF or abort happens in the first IDLE cycle. The new `gnt` is visible one cycle after the IDLE entry.
- A second SOF while in LOCK is a master protocol error. It is ignored; the grant stays locked until EOF.
- The 3-bit `ptr`/`gnt` wrap 4→0. Values 5..7 are never produced.

## Timing
- Reset values (any cycle, including mid-packet): state = IDLE, `gnt` = 0, `ptr` = 0, `gnt_valid` = 0, `busy` = 0, `timeout` = 0, watchdog counter = 0. An in-flight packet is abandoned without a pulse.
- `req` to `gnt` latency: 1 cycle (registered).
- EOF accepted at edge N: `busy` low after N; new `gnt` registered at edge N+1.
- Minimum gap between packets from different masters: 1 idle cycle.
- Back-to-back packets from the same master: no gap, provided it is still the candidate-order winner.
- `timeout` is asserted for exactly one cycle, coincident with `busy` falling.
- No combinational path from inputs to outputs. All outputs are flops.

## Structure
- Package `hm_trn_pkg`:
  - `HM_NMASTER` = 5 and `HM_GNT_W` = 3.
  - State enum {`ST_IDLE`, `ST_LOCK`}.
  - Function `hm_inc_mod` (index+1 mod `NMASTER`).
- One sub-module, `hm_rr_pick`: combinational; inputs `req`[4:0] and `ptr`[2:0]; outputs `pick`[2:0] and `any`. Instantiated once.

## Test plan
- Reset then `req`=5'b00100 → `gnt`=2 after 1 cycle; `gnt_valid`=1; `busy`=0.
- Master 1 sends a 4-beat TLP (SOF beat 0, EOF beat 3, `tdst_rdy_n` toggling) while `req`=5'b11111 → `gnt` stays 1 through EOF, `busy`=1 from the cycle after SOF accept; next `gnt`=2.
- All masters request continuously with single-beat SOF+EOF packets → grants cycle 0,1,2,3,4,0.
- `TIMEOUT`=8: SOF accepted from master 3, then `tsrc_rdy_n`=1 → `timeout` pulse 8 cycles after the last accept; `gnt`=4 next.
- `trn_rst` asserted mid-packet of master 2 → next cycle `gnt`=0, `busy`=0, `ptr`=0, `timeout`=0.
- Master 0 presents SOF with `tdst_rdy_n`=1 for 5 cycles while `req`=5'b11111 → `gnt` held at 0 throughout; LOCK is entered on the accept.
